// File: rtl/ntt_pkg.sv
// Shared NTT package: LOGQ-derived widths and butterfly pipeline latency.
// Defining BTF_GS_DIV2_EN adds the halving stage to the butterfly latency.
package ntt_pkg;

   localparam int unsigned LOGQ_DEFAULT = 64;

`ifdef BTF_GS_DIV2_EN
   localparam bit DIV2_EN = 1'b1;
`else
   localparam bit DIV2_EN = 1'b0;
`endif

   // Width of a sum of two residues before the conditional subtract / halving.
   function automatic int unsigned sum_width(input int unsigned logq);
      return logq + 1;
   endfunction

   // Width of a full integer product of two residues.
   function automatic int unsigned prod_width(input int unsigned logq);
      return 2 * logq;
   endfunction

   // Input-to-output latency of the DIF butterfly.
   function automatic int unsigned btf_latency(input int unsigned d_add,
                                               input int unsigned d_mul,
                                               input int unsigned d_red,
                                               input int unsigned d_div2);
      return d_add + d_mul + d_red + (DIV2_EN ? d_div2 : 32'd0);
   endfunction

endpackage

// File: rtl/btf_div2.sv
// Halving mod q for odd q: x/2 for even x, (x+q)/2 for odd x, latency DELAY.
module btf_div2
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ  = LOGQ_DEFAULT,
   parameter int unsigned DELAY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LOGQ-1:0] x,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] y
);

   localparam int unsigned SW = sum_width(LOGQ);

   logic [SW-1:0]   x_even;
   logic [LOGQ-1:0] half;

   // Adding odd q to odd x makes it even without changing the residue.
   always_comb begin
      x_even = x[0] ? (SW'(x) + SW'(q)) : SW'(x);
      half   = LOGQ'(x_even >> 1);
   end

   shiftreg #(.W(LOGQ), .DEPTH(DELAY)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (half),
      .dout (y)
   );

endmodule

// File: rtl/modadd.sv
// Modular addition (a+b) mod q for a, b in [0, q), latency DELAY.
module modadd
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ  = LOGQ_DEFAULT,
   parameter int unsigned DELAY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LOGQ-1:0] a,
   input  logic [LOGQ-1:0] b,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] sum
);

   localparam int unsigned SW = sum_width(LOGQ);

   logic [SW-1:0]   sum_wide;
   logic [LOGQ-1:0] sum_mod;

   // Carry bit kept so a+b >= 2^LOGQ still compares correctly against q.
   always_comb begin
      sum_wide = SW'(a) + SW'(b);
      sum_mod  = (sum_wide >= SW'(q)) ? LOGQ'(sum_wide - SW'(q)) : LOGQ'(sum_wide);
   end

   shiftreg #(.W(LOGQ), .DEPTH(DELAY)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (sum_mod),
      .dout (sum)
   );

endmodule

// File: rtl/modmul.sv
// Modular multiply a*b mod q: integer product over DELAY_MUL, reduction over DELAY_RED.
module modmul
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ      = LOGQ_DEFAULT,
   parameter int unsigned DELAY_MUL = 4,
   parameter int unsigned DELAY_RED = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LOGQ-1:0] a,
   input  logic [LOGQ-1:0] b,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] res
);

   localparam int unsigned PW = prod_width(LOGQ);

   logic [PW-1:0]   prod;
   logic [PW-1:0]   prod_d;
   logic [LOGQ-1:0] red;

   // Pipeline registers trail the combinational operators for retiming.
   always_comb begin
      prod = PW'(a) * PW'(b);
      red  = LOGQ'(prod_d % PW'(q));
   end

   shiftreg #(.W(PW), .DEPTH(DELAY_MUL)) u_mul_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (prod),
      .dout (prod_d)
   );

   shiftreg #(.W(LOGQ), .DEPTH(DELAY_RED)) u_red_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (red),
      .dout (res)
   );

endmodule

// File: rtl/modsub.sv
// Modular subtraction (a-b) mod q for a, b in [0, q), latency DELAY.
module modsub
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ  = LOGQ_DEFAULT,
   parameter int unsigned DELAY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LOGQ-1:0] a,
   input  logic [LOGQ-1:0] b,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] dif
);

   logic [LOGQ-1:0] dif_mod;

   // On underflow the 2^LOGQ wrap cancels when q is added back.
   always_comb begin
      dif_mod = (a >= b) ? LOGQ'(a - b) : LOGQ'(a - b + q);
   end

   shiftreg #(.W(LOGQ), .DEPTH(DELAY)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (dif_mod),
      .dout (dif)
   );

endmodule

// File: rtl/shiftreg.sv
// Fixed-depth delay line with synchronous active-low clear; depth 0 is a wire.
module shiftreg #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctl;
         assign unused_ctl = clk ^ rst;
         assign dout = din;
      end else begin : g_sr
         logic [W-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/btf_dif_gs.sv
// Gentleman-Sande DIF butterfly: out_a = (a+b) mod q, out_b = ((a-b) mod q)*w mod q.
// Defining BTF_GS_DIV2_EN halves both paths mod q ahead of the multiply (+DELAY_DIV2).
module btf_dif_gs
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ       = LOGQ_DEFAULT,
   parameter int unsigned DELAY_ADD  = 1,
   parameter int unsigned DELAY_MUL  = 4,
   parameter int unsigned DELAY_RED  = 4,
   parameter int unsigned DELAY_DIV2 = 1,
   parameter int unsigned NO_MUL     = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [LOGQ-1:0] btf_in_a,
   input  logic [LOGQ-1:0] btf_in_b,
   input  logic [LOGQ-1:0] btf_in_w,
   input  logic [LOGQ-1:0] q,
   output logic            out_valid,
   output logic [LOGQ-1:0] btf_out_a,
   output logic [LOGQ-1:0] btf_out_b,
   output logic            busy
);

   localparam int unsigned L = btf_latency(DELAY_ADD, DELAY_MUL, DELAY_RED, DELAY_DIV2);
`ifdef BTF_GS_DIV2_EN
   localparam int unsigned PRE_MUL = DELAY_ADD + DELAY_DIV2;
`else
   localparam int unsigned PRE_MUL = DELAY_ADD;
`endif
   // The output register itself provides the last reduction cycle.
   localparam int unsigned POST_PRE = DELAY_MUL + DELAY_RED - 1;

   logic [LOGQ-1:0] sum_r, dif_r;
   logic [LOGQ-1:0] sum_h, dif_h;
   logic [LOGQ-1:0] sum_d, dif_d;
   logic [L-1:0]    vld_q, vld_nxt;

   modadd #(.LOGQ(LOGQ), .DELAY(DELAY_ADD)) u_add (
      .clk (clk), .rst (rst), .a (btf_in_a), .b (btf_in_b), .q (q), .sum (sum_r)
   );

   modsub #(.LOGQ(LOGQ), .DELAY(DELAY_ADD)) u_sub (
      .clk (clk), .rst (rst), .a (btf_in_a), .b (btf_in_b), .q (q), .dif (dif_r)
   );

`ifdef BTF_GS_DIV2_EN
   btf_div2 #(.LOGQ(LOGQ), .DELAY(DELAY_DIV2)) u_half_a (
      .clk (clk), .rst (rst), .x (sum_r), .q (q), .y (sum_h)
   );

   btf_div2 #(.LOGQ(LOGQ), .DELAY(DELAY_DIV2)) u_half_b (
      .clk (clk), .rst (rst), .x (dif_r), .q (q), .y (dif_h)
   );
`else
   assign sum_h = sum_r;
   assign dif_h = dif_r;
`endif

   shiftreg #(.W(LOGQ), .DEPTH(POST_PRE)) u_sum_dly (
      .clk (clk), .rst (rst), .din (sum_h), .dout (sum_d)
   );

   // Twiddle is aligned to the difference at the multiplier input.
   generate
      if (NO_MUL != 0) begin : g_no_mul
         logic unused_w;
         assign unused_w = ^btf_in_w;

         shiftreg #(.W(LOGQ), .DEPTH(POST_PRE)) u_dif_dly (
            .clk (clk), .rst (rst), .din (dif_h), .dout (dif_d)
         );
      end else begin : g_mul
         logic [LOGQ-1:0] w_d;

         shiftreg #(.W(LOGQ), .DEPTH(PRE_MUL)) u_w_dly (
            .clk (clk), .rst (rst), .din (btf_in_w), .dout (w_d)
         );

         modmul #(.LOGQ(LOGQ), .DELAY_MUL(DELAY_MUL), .DELAY_RED(DELAY_RED - 1)) u_mul (
            .clk (clk), .rst (rst), .a (dif_h), .b (w_d), .q (q), .res (dif_d)
         );
      end
   endgenerate

   always_comb begin
      vld_nxt = {vld_q[L-2:0], in_valid};
   end

   // Outputs load only when a sample completes, so they hold across gaps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q     <= '0;
         busy      <= 1'b0;
         btf_out_a <= '0;
         btf_out_b <= '0;
      end else begin
         vld_q <= vld_nxt;
         busy  <= |vld_nxt;
         if (vld_q[L-2]) begin
            btf_out_a <= sum_d;
            btf_out_b <= dif_d;
         end
      end
   end

   assign out_valid = vld_q[L-1];

endmodule

// File: tb/tb_btf_dif_gs.sv
// Bench for btf_dif_gs: directed vectors plus randomized streams against a modular-arithmetic model.
module tb_btf_dif_gs;

   localparam int unsigned W = 64;
`ifdef BTF_GS_DIV2_EN
   localparam bit HALVE = 1'b1;
   localparam int L = 10;
`else
   localparam bit HALVE = 1'b0;
   localparam int L = 9;
`endif

   typedef logic [2*W+1:0] wide_t;
   typedef struct {
      int           due;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic [W-1:0] ebn;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0, b = '0, w = '0, q = 64'd17;
   logic         ov0, ov1, busy0, busy1;
   logic [W-1:0] oa0, ob0, oa1, ob1;

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   cyc      = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   btf_dif_gs #(.LOGQ(W), .NO_MUL(0)) u_dut (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .btf_in_a (a), .btf_in_b (b), .btf_in_w (w), .q (q),
      .out_valid (ov0), .btf_out_a (oa0), .btf_out_b (ob0), .busy (busy0)
   );

   btf_dif_gs #(.LOGQ(W), .NO_MUL(1)) u_nomul (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .btf_in_a (a), .btf_in_b (b), .btf_in_w (w), .q (q),
      .out_valid (ov1), .btf_out_a (oa1), .btf_out_b (ob1), .busy (busy1)
   );

   // Halving as multiplication by the inverse of 2, i.e. (q+1)/2.
   function automatic logic [W-1:0] ref_half(input logic [W-1:0] x, input logic [W-1:0] qq);
      wide_t inv2;
      inv2 = (wide_t'(qq) + wide_t'(1)) / wide_t'(2);
      return W'((wide_t'(x) * inv2) % wide_t'(qq));
   endfunction

   function automatic logic [W-1:0] ref_sum(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                            input logic [W-1:0] qq);
      logic [W-1:0] s;
      s = W'((wide_t'(aa) + wide_t'(bb)) % wide_t'(qq));
      if (HALVE) s = ref_half(s, qq);
      return s;
   endfunction

   function automatic logic [W-1:0] ref_dif(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                            input logic [W-1:0] ww, input logic [W-1:0] qq,
                                            input bit nomul);
      logic [W-1:0] d;
      d = W'((wide_t'(aa) + wide_t'(qq) - wide_t'(bb)) % wide_t'(qq));
      if (HALVE) d = ref_half(d, qq);
      if (!nomul) d = W'((wide_t'(d) * wide_t'(ww)) % wide_t'(qq));
      return d;
   endfunction

   function automatic logic [W-1:0] rnd_below(input logic [W-1:0] qq);
      logic [W-1:0] r;
      r = {$urandom(), $urandom()};
      return r % qq;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] ww);
      in_valid = v;
      a = aa;
      b = bb;
      w = ww;
   endtask

   task automatic push_exp();
      exp_t e;
      e.due = cyc + L;
      e.ea  = ref_sum(a, b, q);
      e.eb  = ref_dif(a, b, w, q, 1'b0);
      e.ebn = ref_dif(a, b, w, q, 1'b1);
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b1, 64'd3, 64'd4, 64'd5);
      repeat (3) tick();
      chk_cnt++;
      if ({ov0, ov1, busy0, busy1} !== 4'b0000)
         $display("FAIL reset_ctl got=%b%b%b%b exp=0000", ov0, ov1, busy0, busy1);
      else pass_cnt++;
      chk_cnt++;
      if ((oa0 | ob0 | oa1 | ob1) !== '0)
         $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", oa0, ob0, oa1, ob1);
      else pass_cnt++;
      drive(1'b0, '0, '0, '0);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_known_vectors();
      logic [W-1:0] ea1, eb1, ea2, eb2, ea3, eb3n;
      int s0;
`ifdef BTF_GS_DIV2_EN
      ea1 = 64'd4; eb1 = 64'd2; ea2 = 64'd4; eb2 = 64'd15; ea3 = 64'd2; eb3n = 64'd7;
`else
      ea1 = 64'd8; eb1 = 64'd4; ea2 = 64'd8; eb2 = 64'd13; ea3 = 64'd4; eb3n = 64'd14;
`endif
      q = 64'd17;
      s0 = cyc;
      drive(1'b1, 64'd5, 64'd3, 64'd2);
      tick(); drive(1'b1, 64'd3, 64'd5, 64'd2);
      tick(); drive(1'b1, 64'd9, 64'd12, W'($urandom_range(0, 16)));
      tick(); drive(1'b0, '0, '0, '0);
      while (cyc < s0 + L) tick();
      chk_cnt++;
      if (ov0 !== 1'b1 || oa0 !== ea1 || ob0 !== eb1)
         $display("FAIL known_1 got=%b %0d %0d exp=1 %0d %0d", ov0, oa0, ob0, ea1, eb1);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (ov0 !== 1'b1 || oa0 !== ea2 || ob0 !== eb2)
         $display("FAIL known_wrap got=%b %0d %0d exp=1 %0d %0d", ov0, oa0, ob0, ea2, eb2);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (ov1 !== 1'b1 || oa1 !== ea3 || ob1 !== eb3n)
         $display("FAIL known_nomul got=%b %0d %0d exp=1 %0d %0d", ov1, oa1, ob1, ea3, eb3n);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0 || oa0 !== ea3 || ob1 !== eb3n)
         $display("FAIL known_hold got=%b%b %0d %0d exp=00 %0d %0d", ov0, ov1, oa0, ob1, ea3, eb3n);
      else pass_cnt++;
      chk_cnt++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0)
         $display("FAIL known_idle_busy got=%b%b exp=00", busy0, busy1);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int   sched[$];
      bit   exp_v;
      exp_t e;
      sched = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
      q = {$urandom(), $urandom()} | 64'd1;
      for (int i = 0; i < sched.size() + L + 2; i++) begin
         exp_v = (sb.size() > 0) && (sb[0].due == cyc);
         chk_cnt++;
         if (ov0 !== exp_v || ov1 !== exp_v)
            $display("FAIL b2b_valid cyc=%0d got=%b%b exp=%b", cyc, ov0, ov1, exp_v);
         else pass_cnt++;
         chk_cnt++;
         if (busy0 !== (sb.size() > 0) || busy1 !== (sb.size() > 0))
            $display("FAIL b2b_busy cyc=%0d got=%b%b exp=%b", cyc, busy0, busy1, sb.size() > 0);
         else pass_cnt++;
         if (exp_v) begin
            e = sb.pop_front();
            chk_cnt++;
            if (oa0 !== e.ea || ob0 !== e.eb || oa1 !== e.ea || ob1 !== e.ebn)
               $display("FAIL b2b_data cyc=%0d got=%0h %0h %0h %0h exp=%0h %0h %0h %0h",
                        cyc, oa0, ob0, oa1, ob1, e.ea, e.eb, e.ea, e.ebn);
            else pass_cnt++;
         end
         if (i < sched.size() && sched[i] == 1) begin
            drive(1'b1, rnd_below(q), rnd_below(q), rnd_below(q));
            push_exp();
         end else begin
            drive(1'b0, '0, '0, '0);
         end
         tick();
      end
   endtask

   task automatic test_random();
      bit   exp_v;
      exp_t e;
      for (int r = 0; r < 3; r++) begin
         if (r == 0) q = W'($urandom_range(3, 1000)) | 64'd1;
         else        q = {$urandom(), $urandom()} | 64'd1;
         for (int i = 0; i < 250 + L + 2; i++) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            chk_cnt++;
            if (ov0 !== exp_v || ov1 !== exp_v)
               $display("FAIL rand_valid cyc=%0d got=%b%b exp=%b", cyc, ov0, ov1, exp_v);
            else pass_cnt++;
            if (exp_v) begin
               e = sb.pop_front();
               chk_cnt++;
               if (oa0 !== e.ea || ob0 !== e.eb || oa1 !== e.ea || ob1 !== e.ebn)
                  $display("FAIL rand_data cyc=%0d q=%0h got=%0h %0h %0h %0h exp=%0h %0h %0h %0h",
                           cyc, q, oa0, ob0, oa1, ob1, e.ea, e.eb, e.ea, e.ebn);
               else pass_cnt++;
            end
            if (i < 250 && $urandom_range(0, 9) < 7) begin
               drive(1'b1, rnd_below(q), rnd_below(q), rnd_below(q));
               push_exp();
            end else begin
               drive(1'b0, '0, '0, '0);
            end
            tick();
         end
      end
   endtask

   task automatic test_mid_reset();
      q = {$urandom(), $urandom()} | 64'd1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rnd_below(q), rnd_below(q), rnd_below(q));
         tick();
      end
      drive(1'b1, rnd_below(q), rnd_below(q), rnd_below(q));
      rst = 1'b0;
      tick();
      chk_cnt++;
      if ({ov0, ov1, busy0, busy1} !== 4'b0000)
         $display("FAIL midrst_ctl got=%b%b%b%b exp=0000", ov0, ov1, busy0, busy1);
      else pass_cnt++;
      chk_cnt++;
      if ((oa0 | ob0 | oa1 | ob1) !== '0)
         $display("FAIL midrst_data got=%0h/%0h/%0h/%0h exp=0", oa0, ob0, oa1, ob1);
      else pass_cnt++;
      rst = 1'b1;
      drive(1'b0, '0, '0, '0);
      for (int i = 0; i < L + 3; i++) begin
         tick();
         chk_cnt++;
         if ({ov0, ov1, busy0, busy1} !== 4'b0000)
            $display("FAIL midrst_flush cyc=%0d got=%b%b%b%b exp=0000", cyc, ov0, ov1, busy0, busy1);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1);
   end

endmodule

// File: doc/btf_dif_gs.md
BTF_DIF_GS -- requirements
Module: btf_dif_gs

Interface
REQ-001 Parameter LOGQ, default 64: coefficient and modulus width in bits.
REQ-002 Parameter DELAY_ADD, default 1: latency of modadd/modsub in cycles.
REQ-003 Parameter DELAY_MUL, default 4: integer multiply latency in cycles.
REQ-004 Parameter DELAY_RED, default 4: modular reduction latency in cycles.
REQ-005 Parameter DELAY_DIV2, default 1: latency of the halving unit in cycles; used only when the halving feature is compiled in.
REQ-006 Parameter NO_MUL, default 0: when set to 1, the twiddle is treated as 1 and the multiplier is replaced by an equal-latency delay.
REQ-007 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-low.
REQ-009 in_valid  input  1  qualifies btf_in_a, btf_in_b and btf_in_w in the same cycle.
REQ-010 btf_in_a  input  LOGQ  upper operand, in range [0, q).
REQ-011 btf_in_b  input  LOGQ  lower operand, in range [0, q).
REQ-012 btf_in_w  input  LOGQ  twiddle factor, in range [0, q).
REQ-013 q  input  LOGQ  odd modulus; held static while any sample is in flight.
REQ-014 out_valid  output  1  qualifies both data outputs.
REQ-015 btf_out_a  output  LOGQ  sum-path result.
REQ-016 btf_out_b  output  LOGQ  difference-path result.
REQ-017 busy  output  1  high while at least one accepted sample has not yet appeared at the output.

Function
REQ-018 The block SHALL compute the Gentleman-Sande DIF butterfly: btf_out_a = (a+b) mod q and btf_out_b = ((a-b) mod q)*w mod q.
REQ-019 The block SHALL be fully pipelined, accepting one sample per cycle with no backpressure; in_valid gaps are allowed.
REQ-020 Latency SHALL be fixed at L = DELAY_ADD+DELAY_MUL+DELAY_RED cycles from in_valid to out_valid, independent of NO_MUL.
REQ-021 The sum path SHALL be delay-matched through a shift register so that btf_out_a and btf_out_b of the same sample appear in the same cycle.
REQ-022 A valid shift register of depth L SHALL track samples; out_valid SHALL be the valid bit of the last stage.
REQ-023 busy SHALL equal the OR of all valid-pipeline bits.
REQ-024 Subtraction underflow SHALL wrap: a<b yields a-b+q.
REQ-025 Addition SHALL use a LOGQ+1-bit intermediate with a conditional subtract of q.
REQ-026 Data outputs SHALL be registered and SHALL hold their last value while out_valid is low.
REQ-027 in_valid arriving in the same cycle that out_valid is asserted for an earlier sample SHALL not disturb either sample.

Reset
REQ-028 When rst is sampled low, all valid bits, out_valid, busy, btf_out_a and btf_out_b SHALL be 0 on the next cycle.
REQ-029 A reset asserted mid-operation SHALL discard every in-flight sample; no out_valid SHALL be produced for samples accepted before the reset.
REQ-030 in_valid SHALL be ignored in any cycle in which rst is low.

Configuration
REQ-031 Macro BTF_GS_DIV2_EN: when defined, both the sum and the difference SHALL be halved mod q before the multiply, and L SHALL increase by DELAY_DIV2.
REQ-032 Halving SHALL be x>>1 for even x and (x+q)>>1 for odd x, using a LOGQ+1-bit intermediate.
REQ-033 When BTF_GS_DIV2_EN is undefined, no halving logic SHALL be generated and L SHALL be as stated in REQ-020.

Structure
REQ-034 The latency formula and the LOGQ-derived width constants SHALL reside in the shared ntt package.
REQ-035 The block SHALL reuse the existing modadd, modsub, modmul and shiftreg modules.
REQ-036 One new sub-module, btf_div2, SHALL implement the halving unit with latency DELAY_DIV2.

Verification
REQ-037 q=17, a=5, b=3, w=2, macro off -> after L cycles, btf_out_a=8 and btf_out_b=4.
REQ-038 q=17, a=3, b=5, w=2, macro off -> btf_out_a=8 and btf_out_b=13 (wrap-around case).
REQ-039 q=17, a=3, b=5, w=2, macro on -> btf_out_a=4 and btf_out_b=15 (odd halving: 15 -> 16).
REQ-040 Ten back-to-back samples followed by three with gaps -> each result appears exactly L cycles after its input, with matching gaps.
REQ-041 rst driven low with three samples in flight -> no out_valid, outputs 0 and busy 0 on the next cycle.
REQ-042 NO_MUL=1, q=17, a=9, b=12, any w -> btf_out_b=14 after L cycles.
